// File: rtl/pipe_wall_chain_pkg.sv
// Shared defaults and stage naming for the TiniSOC pipeline register walls.
package pipe_pkg;

  localparam int PIPE_WIDTH     = 32;
  localparam int PIPE_STAGES    = 4;
  localparam int PIPE_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    STG_IF_ID  = 2'd0,
    STG_ID_EX  = 2'd1,
    STG_EX_MEM = 2'd2,
    STG_MEM_WB = 2'd3
  } stageIdxT;

endpackage

// File: rtl/pipe_wall_chain_stage.sv
// One pipeline wall: a valid bit plus payload with flush > hold > bubble > load priority.
module pipe_wall_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH        = PIPE_WIDTH,
  parameter int ZERO_ON_KILL = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             bubble,
  input  logic             flush,
  input  logic             upValid,
  input  logic [WIDTH-1:0] upData,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // A killed stage (flush or bubble) always drops valid; the payload is only
  // scrubbed when the chain is built to zero dead slots.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      if (ZERO_ON_KILL != 0) data <= '0;
    end else if (!hold) begin
      if (bubble) begin
        valid <= 1'b0;
        if (ZERO_ON_KILL != 0) data <= '0;
      end else begin
        valid <= upValid;
        data  <= upData;
      end
    end
  end

endmodule

// File: rtl/pipe_wall_chain.sv
// STAGES-deep register chain with per-stage flush/stall, automatic bubble
// insertion below a stall, and a saturating bubble-cycle counter.
module pipe_wall_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH        = PIPE_WIDTH,
  parameter int STAGES       = PIPE_STAGES,
  parameter int ZERO_ON_KILL = 1,
  parameter int CNT_WIDTH    = PIPE_CNT_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_WIDTH-1:0]    bubble_count,
  input  logic                    clr_count
);

  logic [STAGES-1:0]    hold;
  logic [STAGES-1:0]    bubble;
  logic                 bubbleEvent;
  logic [CNT_WIDTH-1:0] bubbleCount;
  logic                 stageValid [STAGES];
  logic [WIDTH-1:0]     stageData  [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    // A stall anywhere downstream freezes this stage too.
    assign hold[k] = |stall[STAGES-1:k];

    if (k == 0) begin : gFirst
      assign bubble[k] = 1'b0;

      pipe_wall_stage #(
        .WIDTH        (WIDTH),
        .ZERO_ON_KILL (ZERO_ON_KILL)
      ) uStage (
        .clock   (clock),
        .reset_n (reset_n),
        .hold    (hold[k]),
        .bubble  (bubble[k]),
        .flush   (flush[k]),
        .upValid (in_valid),
        .upData  (in_data),
        .valid   (stageValid[k]),
        .data    (stageData[k])
      );
    end else begin : gRest
      // Bubble only where the freeze boundary sits and the stage is not flushed.
      assign bubble[k] = hold[k-1] & ~hold[k] & ~flush[k];

      pipe_wall_stage #(
        .WIDTH        (WIDTH),
        .ZERO_ON_KILL (ZERO_ON_KILL)
      ) uStage (
        .clock   (clock),
        .reset_n (reset_n),
        .hold    (hold[k]),
        .bubble  (bubble[k]),
        .flush   (flush[k]),
        .upValid (stageValid[k-1]),
        .upData  (stageData[k-1]),
        .valid   (stageValid[k]),
        .data    (stageData[k])
      );
    end

    assign stage_valid[k]                = stageValid[k];
    assign stage_data[k*WIDTH +: WIDTH]  = stageData[k];
  end

  assign bubbleEvent = |bubble;
  assign in_ready    = ~hold[0];
  assign out_valid   = stageValid[STAGES-1];
  assign out_data    = stageData[STAGES-1];

  // Counts cycles with any bubble; clear wins over increment and the count sticks at all-ones.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bubbleCount <= '0;
    end else if (clr_count) begin
      bubbleCount <= '0;
    end else if (bubbleEvent && (bubbleCount != {CNT_WIDTH{1'b1}})) begin
      bubbleCount <= bubbleCount + CNT_WIDTH'(1);
    end
  end

  assign bubble_count = bubbleCount;

endmodule

// File: tb/tb_pipe_wall_chain.sv
// Bench for pipe_wall_chain: a default instance and a ZERO_ON_KILL=0, CNT_WIDTH=4 instance share stimulus.
module tb_pipe_wall_chain;

  localparam int W = 32;
  localparam int S = 4;

  logic           clock = 1'b0;
  logic           reset_n, in_valid, clr_count;
  logic [W-1:0]   in_data;
  logic [S-1:0]   stall, flush;

  logic           inReadyA, outValidA;
  logic [S-1:0]   stageValidA;
  logic [S*W-1:0] stageDataA;
  logic [W-1:0]   outDataA;
  logic [15:0]    bubbleCountA;

  logic           inReadyB, outValidB;
  logic [S-1:0]   stageValidB;
  logic [S*W-1:0] stageDataB;
  logic [W-1:0]   outDataB;
  logic [3:0]     bubbleCountB;

  int             checks = 0;
  int             errors = 0;
  bit             scoreOn = 1'b0;
  logic [W-1:0]   expQ [$];

  always #5 clock = ~clock;

  pipe_wall_chain #(.WIDTH(W), .STAGES(S), .ZERO_ON_KILL(1), .CNT_WIDTH(16)) dutA (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(inReadyA), .stall(stall), .flush(flush), .stage_valid(stageValidA),
    .stage_data(stageDataA), .out_valid(outValidA), .out_data(outDataA),
    .bubble_count(bubbleCountA), .clr_count(clr_count)
  );

  pipe_wall_chain #(.WIDTH(W), .STAGES(S), .ZERO_ON_KILL(0), .CNT_WIDTH(4)) dutB (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(inReadyB), .stall(stall), .flush(flush), .stage_valid(stageValidB),
    .stage_data(stageDataB), .out_valid(outValidB), .out_data(outDataB),
    .bubble_count(bubbleCountB), .clr_count(clr_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one cycle of inputs; accepted valid words become expected output.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                               input logic [S-1:0] st, input logic [S-1:0] fl);
    in_valid = v;
    in_data  = d;
    stall    = st;
    flush    = fl;
    #1;
    if (scoreOn && v && inReadyA) expQ.push_back(d);
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    clr_count = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    reset_n = 1'b1;
    expQ.delete();
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (stageValidA !== 4'h0) begin errors++; $display("[TB] FAIL reset_valid: got %h expected %h", stageValidA, 4'h0); end
    checks++; if (stageDataA !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", stageDataA); end
    checks++; if (stageDataB !== '0) begin errors++; $display("[TB] FAIL reset_dataB: got %h expected 0", stageDataB); end
    checks++; if (bubbleCountA !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bubbleCountA); end
    checks++; if (outValidA !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValidA); end
    checks++; if (inReadyA !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", inReadyA); end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    int firstAt = -1;
    int lastAt = -1;
    logic [W-1:0] exp;
    doReset();
    scoreOn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) applyStimulus(1'b1, 32'hA0 + c, '0, '0);
      else       applyStimulus(1'b0, '0, '0, '0);
      tick();
      if (outValidA) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL stream_extra: got %h expected no output", outDataA);
        end else begin
          exp = expQ.pop_front();
          if (outDataA !== exp) begin errors++; $display("[TB] FAIL stream_data: got %h expected %h", outDataA, exp); end
        end
        if (firstAt < 0) firstAt = c + 1;
        lastAt = c + 1;
        seen++;
      end
    end
    checks++; if (firstAt !== 4) begin errors++; $display("[TB] FAIL stream_latency: got %0d expected 4", firstAt); end
    checks++; if (lastAt !== 11) begin errors++; $display("[TB] FAIL stream_last: got %0d expected 11", lastAt); end
    checks++; if (seen !== 8) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 8", seen); end
    checks++; if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL stream_leftover: got %0d expected 0", expQ.size()); end
    checks++; if (bubbleCountA !== 16'd0) begin errors++; $display("[TB] FAIL stream_bubbles: got %0d expected 0", bubbleCountA); end
    scoreOn = 1'b0;
  endtask

  task automatic test_stall_bubble();
    int outAt = -1;
    logic [W-1:0] exp;
    doReset();
    scoreOn = 1'b1;
    applyStimulus(1'b1, 32'hB0, '0, '0); tick();
    applyStimulus(1'b1, 32'hB1, '0, '0); tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'hB2, 4'b0010, '0);
      checks++; if (inReadyA !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready: got %b expected 0", inReadyA); end
      tick();
      checks++; if (stageDataA[0*W +: W] !== 32'hB1 || stageValidA[0] !== 1'b1) begin errors++; $display("[TB] FAIL stall_s0: got %h/%b expected b1/1", stageDataA[0*W +: W], stageValidA[0]); end
      checks++; if (stageDataA[1*W +: W] !== 32'hB0 || stageValidA[1] !== 1'b1) begin errors++; $display("[TB] FAIL stall_s1: got %h/%b expected b0/1", stageDataA[1*W +: W], stageValidA[1]); end
      checks++; if (stageDataA[2*W +: W] !== 32'h0 || stageValidA[2] !== 1'b0) begin errors++; $display("[TB] FAIL stall_s2_bubble: got %h/%b expected 0/0", stageDataA[2*W +: W], stageValidA[2]); end
      checks++; if (stageValidB[2] !== 1'b0) begin errors++; $display("[TB] FAIL stall_s2_bubbleB: got %b expected 0", stageValidB[2]); end
      checks++; if (bubbleCountA !== 16'(i + 1)) begin errors++; $display("[TB] FAIL stall_count: got %0d expected %0d", bubbleCountA, i + 1); end
      checks++; if (bubbleCountB !== 4'(i + 1)) begin errors++; $display("[TB] FAIL stall_countB: got %0d expected %0d", bubbleCountB, i + 1); end
    end
    for (int c = 0; c < 8; c++) begin
      if (c == 0) applyStimulus(1'b1, 32'hB2, '0, '0);
      else        applyStimulus(1'b0, '0, '0, '0);
      tick();
      if (outValidA) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL stall_extra: got %h expected no output", outDataA);
        end else begin
          exp = expQ.pop_front();
          if (outDataA !== exp) begin errors++; $display("[TB] FAIL stall_out_data: got %h expected %h", outDataA, exp); end
        end
        if (outAt < 0) outAt = c + 1;
      end
    end
    checks++; if (outAt !== 2) begin errors++; $display("[TB] FAIL stall_release_latency: got %0d expected 2", outAt); end
    checks++; if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL stall_leftover: got %0d expected 0", expQ.size()); end
    scoreOn = 1'b0;
  endtask

  task automatic test_flush_stall();
    doReset();
    applyStimulus(1'b1, 32'hC0, '0, '0); tick();
    applyStimulus(1'b1, 32'hC1, '0, '0); tick();
    applyStimulus(1'b1, 32'hC2, '0, '0); tick();
    applyStimulus(1'b1, 32'hC3, 4'b0100, 4'b0100); tick();
    checks++; if (stageDataA[2*W +: W] !== 32'h0 || stageValidA[2] !== 1'b0) begin errors++; $display("[TB] FAIL flush_s2: got %h/%b expected 0/0", stageDataA[2*W +: W], stageValidA[2]); end
    checks++; if (stageDataB[2*W +: W] !== 32'hC0 || stageValidB[2] !== 1'b0) begin errors++; $display("[TB] FAIL flush_s2B: got %h/%b expected c0/0", stageDataB[2*W +: W], stageValidB[2]); end
    checks++; if (stageDataA[3*W +: W] !== 32'h0 || stageValidA[3] !== 1'b0) begin errors++; $display("[TB] FAIL flush_s3_bubble: got %h/%b expected 0/0", stageDataA[3*W +: W], stageValidA[3]); end
    checks++; if (stageDataA[1*W +: W] !== 32'hC1 || stageDataA[0*W +: W] !== 32'hC2) begin errors++; $display("[TB] FAIL flush_upstream_hold: got %h,%h expected c1,c2", stageDataA[1*W +: W], stageDataA[0*W +: W]); end
    checks++; if (bubbleCountA !== 16'd1) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 1", bubbleCountA); end
    applyStimulus(1'b1, 32'hC3, 4'b0100, 4'b0000); tick();
    checks++; if (stageValidA !== 4'b0011) begin errors++; $display("[TB] FAIL flush_stays_empty: got %b expected 0011", stageValidA); end
    checks++; if (bubbleCountA !== 16'd2) begin errors++; $display("[TB] FAIL flush_count2: got %0d expected 2", bubbleCountA); end
  endtask

  task automatic test_last_stall();
    applyStimulus(1'b1, 32'hC3, 4'b1000, '0);
    checks++; if (inReadyA !== 1'b0) begin errors++; $display("[TB] FAIL last_stall_ready: got %b expected 0", inReadyA); end
    tick();
    checks++; if (bubbleCountA !== 16'd2) begin errors++; $display("[TB] FAIL last_stall_count: got %0d expected 2", bubbleCountA); end
    checks++; if (stageDataA[0*W +: W] !== 32'hC2 || stageValidA !== 4'b0011) begin errors++; $display("[TB] FAIL last_stall_hold: got %h/%b expected c2/0011", stageDataA[0*W +: W], stageValidA); end
  endtask

  task automatic test_zero_on_kill();
    doReset();
    applyStimulus(1'b1, 32'hD0, '0, '0); tick();
    applyStimulus(1'b1, 32'hD1, '0, 4'b0001); tick();
    checks++; if (stageDataB[0*W +: W] !== 32'hD0 || stageValidB[0] !== 1'b0) begin errors++; $display("[TB] FAIL keep_payload_s0B: got %h/%b expected d0/0", stageDataB[0*W +: W], stageValidB[0]); end
    checks++; if (stageDataA[0*W +: W] !== 32'h0 || stageValidA[0] !== 1'b0) begin errors++; $display("[TB] FAIL zero_payload_s0: got %h/%b expected 0/0", stageDataA[0*W +: W], stageValidA[0]); end
    checks++; if (stageDataB[1*W +: W] !== 32'hD0 || stageValidB[1] !== 1'b1) begin errors++; $display("[TB] FAIL flush_s1_load: got %h/%b expected d0/1", stageDataB[1*W +: W], stageValidB[1]); end
  endtask

  task automatic test_saturation();
    logic [3:0] expB;
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, '0, 4'b0001, '0);
      tick();
      expB = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      checks++; if (bubbleCountB !== expB) begin errors++; $display("[TB] FAIL sat_countB: got %0d expected %0d", bubbleCountB, expB); end
    end
    checks++; if (bubbleCountA !== 16'd20) begin errors++; $display("[TB] FAIL sat_countA: got %0d expected 20", bubbleCountA); end
    clr_count = 1'b1;
    applyStimulus(1'b0, '0, 4'b0001, '0); tick();
    checks++; if (bubbleCountB !== 4'd0 || bubbleCountA !== 16'd0) begin errors++; $display("[TB] FAIL clear_priority: got %0d,%0d expected 0,0", bubbleCountA, bubbleCountB); end
    clr_count = 1'b0;
    applyStimulus(1'b0, '0, 4'b0001, '0); tick();
    checks++; if (bubbleCountB !== 4'd1) begin errors++; $display("[TB] FAIL clear_resume: got %0d expected 1", bubbleCountB); end
  endtask

  task automatic test_reset_midstream();
    int outAt = -1;
    logic [W-1:0] exp;
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hE0 + i, '0, '0); tick();
    end
    checks++; if (stageValidA !== 4'hF) begin errors++; $display("[TB] FAIL mid_full: got %b expected 1111", stageValidA); end
    applyStimulus(1'b1, 32'hE4, 4'b0100, '0); tick();
    checks++; if (bubbleCountA !== 16'd1) begin errors++; $display("[TB] FAIL mid_bubble: got %0d expected 1", bubbleCountA); end
    reset_n = 1'b0;
    applyStimulus(1'b1, 32'hE5, 4'b0100, 4'b0010); tick();
    checks++; if (stageValidA !== 4'h0 || stageValidB !== 4'h0) begin errors++; $display("[TB] FAIL mid_reset_valid: got %b,%b expected 0000", stageValidA, stageValidB); end
    checks++; if (stageDataA !== '0 || stageDataB !== '0) begin errors++; $display("[TB] FAIL mid_reset_data: got %h expected 0", stageDataA); end
    checks++; if (bubbleCountA !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", bubbleCountA); end
    reset_n = 1'b1;
    expQ.delete();
    scoreOn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) applyStimulus(1'b1, 32'hF0, '0, '0);
      else        applyStimulus(1'b0, '0, '0, '0);
      tick();
      if (outValidA) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL mid_extra: got %h expected no output", outDataA);
        end else begin
          exp = expQ.pop_front();
          if (outDataA !== exp) begin errors++; $display("[TB] FAIL mid_out_data: got %h expected %h", outDataA, exp); end
        end
        if (outAt < 0) outAt = c + 1;
      end
    end
    checks++; if (outAt !== 4) begin errors++; $display("[TB] FAIL mid_latency: got %0d expected 4", outAt); end
    scoreOn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    clr_count = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    stall     = '0;
    flush     = '0;
    test_reset();
    test_back_to_back();
    test_stall_bubble();
    test_flush_stall();
    test_last_stall();
    test_zero_on_kill();
    test_saturation();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
